// File: rtl/pwm_feed_pkg.sv
// pwm_feed_pkg: shared state encoding and output sample width for the PWM sample feeder
package pwm_feed_pkg;
  localparam int OUT_W = 8;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two FIFO with occupancy output; pointers carry an extra wrap bit
module sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_wr, w_rd;
  assign level = r_wptr - r_rptr;
  assign full  = level == FULL_LVL;
  assign empty = level == '0;
  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: buffers CORDIC samples and feeds one quantized 8-bit sample per PWM frame.
// Define PWM_FEED_ROUND_EN for round-half-up quantization with positive saturation.
module pwm_sample_feeder
  import pwm_feed_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int FRAME_LEN = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] sample,
  output logic             sample_stb,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);
  localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_live;
  logic            w_full, w_empty, w_push, w_pop, w_tick, w_fill, w_wrap;
  logic [IN_W-1:0] w_head;
  logic [LW-1:0]   w_level;
  logic [OUT_W-1:0] w_quant;
  sample_fifo #(.W(IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .pop(w_pop), .wdata(in_data),
    .rdata(w_head), .full(w_full), .empty(w_empty), .level(w_level)
  );
  assign in_ready = r_live && !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_fill   = w_level >= LW'(2);
  assign w_wrap   = r_cnt == CW'(FRAME_LEN - 1);
  // The PRIME->RUN transition cycle carries the first frame tick
  assign w_tick   = enable && ((r_state == PRIME && w_fill) || (r_state == RUN && w_wrap));
  assign w_pop    = w_tick && !w_empty;
`ifdef PWM_FEED_ROUND_EN
  logic [IN_W:0] w_sum;
  assign w_sum   = {w_head[IN_W-1], w_head} + (IN_W+1)'(1 << (IN_W - 9));
  assign w_quant = (w_sum[IN_W] != w_sum[IN_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}} : w_sum[IN_W-1 -: OUT_W];
`else
  assign w_quant = w_head[IN_W-1 -: OUT_W];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_live       <= 1'b0;
      sample       <= '0;
      sample_stb   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      r_live     <= 1'b1;
      sample_stb <= w_pop;
      underrun   <= w_tick && w_empty;
      if (w_pop) sample <= w_quant;
      if (w_tick && w_empty && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      r_state <= !enable ? IDLE : r_state == IDLE ? PRIME : (r_state == PRIME && w_fill) ? RUN : r_state;
      r_cnt   <= (enable && r_state == RUN && !w_wrap) ? r_cnt + CW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb_pwm_sample_feeder: directed self-checking bench for pwm_sample_feeder (FRAME_LEN=8)
module tb_pwm_sample_feeder;
  import pwm_feed_pkg::*;
  localparam int FL = 8;
`ifdef PWM_FEED_ROUND_EN
  localparam logic [7:0] Q_SMALL = 8'h01;
`else
  localparam logic [7:0] Q_SMALL = 8'h00;
`endif
  logic clk = 0, rst = 1, enable = 0, in_valid = 0;
  logic [15:0] in_data = '0;
  logic in_ready, sample_stb, underrun;
  logic [7:0] sample, underrun_cnt;
  int n_cmp = 0, n_bad = 0;
  pwm_sample_feeder #(.IN_W(16), .FRAME_LEN(FL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sample(sample), .sample_stb(sample_stb),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push1(input logic [15:0] d);
    in_valid = 1;
    in_data = d;
    step(1);
    in_valid = 0;
  endtask
  task automatic reset_cycle();
    rst = 1;
    enable = 0;
    in_valid = 0;
    step(1);
    rst = 0;
    step(1);
  endtask
  initial begin
    step(2);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_stb", 32'(sample_stb), 0);
    chk("rst_und", 32'(underrun), 0);
    chk("rst_ucnt", 32'(underrun_cnt), 0);
    rst = 0;
    step(1);
    chk("rel_ready", 32'(in_ready), 1);
    chk("rel_level", 32'(dut.w_level), 0);
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("prime_state", 32'(dut.r_state), 32'(PRIME));
      chk("prime_stb", 32'(sample_stb), 0);
      chk("prime_und", 32'(underrun), 0);
      chk("prime_sample", 32'(sample), 0);
    end
    enable = 0;
    step(1);
    chk("idle_state", 32'(dut.r_state), 32'(IDLE));
    push1(16'h1234);
    push1(16'h8000);
    chk("two_level", 32'(dut.w_level), 2);
    enable = 1;
    step(1);
    chk("entry_prime", 32'(dut.r_state), 32'(PRIME));
    chk("entry_stb0", 32'(sample_stb), 0);
    step(1);
    chk("run_state", 32'(dut.r_state), 32'(RUN));
    chk("first_stb", 32'(sample_stb), 1);
    chk("first_sample", 32'(sample), 32'h12);
    chk("first_level", 32'(dut.w_level), 1);
    for (int i = 0; i < FL - 1; i++) begin
      step(1);
      chk("mid_stb", 32'(sample_stb), 0);
      chk("mid_sample", 32'(sample), 32'h12);
    end
    step(1);
    chk("second_stb", 32'(sample_stb), 1);
    chk("second_sample", 32'(sample), 32'h80);
    for (int i = 0; i < FL - 1; i++) begin
      step(1);
      chk("pre_und", 32'(underrun), 0);
    end
    step(1);
    chk("und_pulse", 32'(underrun), 1);
    chk("und_cnt1", 32'(underrun_cnt), 1);
    chk("und_hold", 32'(sample), 32'h80);
    chk("und_stb", 32'(sample_stb), 0);
    step(FL - 1);
    push1(16'h4000);
    chk("pushtick_und", 32'(underrun), 1);
    chk("pushtick_cnt", 32'(underrun_cnt), 2);
    chk("pushtick_lvl", 32'(dut.w_level), 1);
    step(FL - 1);
    push1(16'hC000);
    chk("pushpop_stb", 32'(sample_stb), 1);
    chk("pushpop_smp", 32'(sample), 32'h40);
    chk("pushpop_lvl", 32'(dut.w_level), 1);
    chk("pushpop_und", 32'(underrun), 0);
    enable = 0;
    step(2);
    chk("stop_idle", 32'(dut.r_state), 32'(IDLE));
    chk("stop_hold", 32'(sample), 32'h40);
    reset_cycle();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'(16'h1100 * (i + 1));
      step(1);
    end
    chk("full_ready", 32'(in_ready), 0);
    chk("full_level", 32'(dut.w_level), 4);
    in_data = 16'hEEEE;
    step(1);
    in_valid = 0;
    chk("full_level5", 32'(dut.w_level), 4);
    chk("full_head", 32'(dut.w_head), 32'h1100);
    reset_cycle();
    push1(16'h7FF0);
    push1(16'h0080);
    enable = 1;
    step(2);
    chk("q_big", 32'(sample), 32'h7F);
    step(FL);
    chk("q_small_stb", 32'(sample_stb), 1);
    chk("q_small", 32'(sample), 32'(Q_SMALL));
    reset_cycle();
    push1(16'h1000);
    push1(16'h2000);
    push1(16'h3000);
    push1(16'h4000);
    enable = 1;
    step(2);
    chk("mr_sample", 32'(sample), 32'h10);
    chk("mr_level", 32'(dut.w_level), 3);
    step(3);
    rst = 1;
    enable = 0;
    step(1);
    chk("mr_rst_smp", 32'(sample), 0);
    chk("mr_rst_rdy", 32'(in_ready), 0);
    chk("mr_rst_ucnt", 32'(underrun_cnt), 0);
    chk("mr_rst_stb", 32'(sample_stb), 0);
    chk("mr_rst_st", 32'(dut.r_state), 32'(IDLE));
    rst = 0;
    step(1);
    chk("mr_rel_lvl", 32'(dut.w_level), 0);
    chk("mr_rel_rdy", 32'(in_ready), 1);
    push1(16'h5000);
    push1(16'h6000);
    enable = 1;
    step(1 + FL * 270);
    chk("sat_cnt", 32'(underrun_cnt), 255);
    chk("sat_hold", 32'(sample), 32'h60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
